pipeline_stage_regs: RTL and testbench

Pipeline register bank and operand-forwarding datapath on the opposite side of `pipeline_controller`. It holds the R/X/M/W instruction registers and the result registers that `pipeline_controller` reads, and applies its stall enables (`en_*`) and one-hot forwarding vectors (`forwarding_sr`/`forwarding_tr`). It inserts NOP bubbles on load-use stalls and delivers the resolved source/target operands to the X stage. It sits between fetch, register file, ALU and data memory in the CPU top level.

---
 rtl/pipeline_stage_regs_pkg.sv | 18 +
 rtl/pipeline_stage_regs_fwd_mux.sv | 27 ++
 rtl/pipeline_stage_regs.sv | 141 ++++++++++++++
 tb/tb_pipeline_stage_regs.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_stage_regs_pkg.sv
// Shared constants for the pipeline register bank: NOP encoding,
// forwarding-vector bit positions and default word width.
package pipeline_stage_regs_pkg;

    localparam int WIDTH_DEF = 16;

    localparam logic [15:0] NOP16 = 16'hF000;

    localparam int FWD_BITS = 5;
    localparam int FWD_X    = 4;
    localparam int FWD_MA   = 3;
    localparam int FWD_MM   = 2;
    localparam int FWD_WA   = 1;
    localparam int FWD_WM   = 0;

    typedef logic [FWD_BITS-1:0] fwd_vec_t;

endpackage

// File: rtl/pipeline_stage_regs_fwd_mux.sv
// Five-way priority operand select (youngest result wins) with
// register-file fallback when no forwarding bit is set.
module pipeline_stage_regs_fwd_mux
    import pipeline_stage_regs_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  fwd_vec_t         sel_i,
    input  logic [WIDTH-1:0] alu_x_i,
    input  logic [WIDTH-1:0] alu_m_i,
    input  logic [WIDTH-1:0] mem_m_i,
    input  logic [WIDTH-1:0] alu_w_i,
    input  logic [WIDTH-1:0] mem_w_i,
    input  logic [WIDTH-1:0] rf_i,
    output logic [WIDTH-1:0] op_o
);

    always_comb begin
        op_o = rf_i;
        if (sel_i[FWD_X])       op_o = alu_x_i;
        else if (sel_i[FWD_MA]) op_o = alu_m_i;
        else if (sel_i[FWD_MM]) op_o = mem_m_i;
        else if (sel_i[FWD_WA]) op_o = alu_w_i;
        else if (sel_i[FWD_WM]) op_o = mem_w_i;
    end

endmodule

// File: rtl/pipeline_stage_regs.sv
// R/X/M/W instruction and result registers with stall enables, bubble
// insertion on load-use stalls and forwarded operand latching into X.
module pipeline_stage_regs
    import pipeline_stage_regs_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] inst_f_i,
    input  logic             en_r_i,
    input  logic             en_x_i,
    input  logic             en_m_i,
    input  logic             en_w_i,
    input  fwd_vec_t         forwarding_sr_i,
    input  fwd_vec_t         forwarding_tr_i,
    input  logic [WIDTH-1:0] rf_sr_i,
    input  logic [WIDTH-1:0] rf_tr_i,
    input  logic [WIDTH-1:0] alu_x_i,
    input  logic [WIDTH-1:0] mem_m_i,
    output logic [WIDTH-1:0] inst_r_o,
    output logic [WIDTH-1:0] inst_x_o,
    output logic [WIDTH-1:0] inst_m_o,
    output logic [WIDTH-1:0] inst_w_o,
    output logic [WIDTH-1:0] op_sr_x_o,
    output logic [WIDTH-1:0] op_tr_x_o,
    output logic [WIDTH-1:0] alu_m_o,
    output logic [WIDTH-1:0] alu_w_o,
    output logic [WIDTH-1:0] mem_w_o,
    output logic [15:0]      bubble_count_o
);

    localparam logic [WIDTH-1:0] NOP = WIDTH'(NOP16);

    logic [WIDTH-1:0] inst_r_q, inst_r_d, inst_x_q, inst_x_d;
    logic [WIDTH-1:0] inst_m_q, inst_m_d, inst_w_q, inst_w_d;
    logic [WIDTH-1:0] op_sr_q, op_sr_d, op_tr_q, op_tr_d;
    logic [WIDTH-1:0] alu_m_q, alu_m_d, alu_w_q, alu_w_d, mem_w_q, mem_w_d;
    logic [15:0]      bubble_q, bubble_d;
    logic [WIDTH-1:0] sel_sr, sel_tr;

    pipeline_stage_regs_fwd_mux #(.WIDTH(WIDTH)) u_fwd_sr (
        .sel_i   (forwarding_sr_i),
        .alu_x_i (alu_x_i),
        .alu_m_i (alu_m_q),
        .mem_m_i (mem_m_i),
        .alu_w_i (alu_w_q),
        .mem_w_i (mem_w_q),
        .rf_i    (rf_sr_i),
        .op_o    (sel_sr)
    );

    pipeline_stage_regs_fwd_mux #(.WIDTH(WIDTH)) u_fwd_tr (
        .sel_i   (forwarding_tr_i),
        .alu_x_i (alu_x_i),
        .alu_m_i (alu_m_q),
        .mem_m_i (mem_m_i),
        .alu_w_i (alu_w_q),
        .mem_w_i (mem_w_q),
        .rf_i    (rf_tr_i),
        .op_o    (sel_tr)
    );

    always_comb begin
        inst_r_d = inst_r_q;
        inst_x_d = inst_x_q;
        inst_m_d = inst_m_q;
        inst_w_d = inst_w_q;
        op_sr_d  = op_sr_q;
        op_tr_d  = op_tr_q;
        alu_m_d  = alu_m_q;
        alu_w_d  = alu_w_q;
        mem_w_d  = mem_w_q;
        bubble_d = bubble_q;

        if (en_r_i) inst_r_d = inst_f_i;

        // X advancing while R is stalled means R's instruction is not ready: bubble.
        if (en_x_i) begin
            if (en_r_i) begin
                inst_x_d = inst_r_q;
                op_sr_d  = sel_sr;
                op_tr_d  = sel_tr;
            end else begin
                inst_x_d = NOP;
                op_sr_d  = '0;
                op_tr_d  = '0;
                if (bubble_q != 16'hFFFF) bubble_d = bubble_q + 16'd1;
            end
        end

        if (en_m_i) begin
            inst_m_d = inst_x_q;
            alu_m_d  = alu_x_i;
        end

        if (en_w_i) begin
            inst_w_d = inst_m_q;
            alu_w_d  = alu_m_q;
            mem_w_d  = mem_m_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inst_r_q <= NOP;
            inst_x_q <= NOP;
            inst_m_q <= NOP;
            inst_w_q <= NOP;
            op_sr_q  <= '0;
            op_tr_q  <= '0;
            alu_m_q  <= '0;
            alu_w_q  <= '0;
            mem_w_q  <= '0;
            bubble_q <= '0;
        end else begin
            inst_r_q <= inst_r_d;
            inst_x_q <= inst_x_d;
            inst_m_q <= inst_m_d;
            inst_w_q <= inst_w_d;
            op_sr_q  <= op_sr_d;
            op_tr_q  <= op_tr_d;
            alu_m_q  <= alu_m_d;
            alu_w_q  <= alu_w_d;
            mem_w_q  <= mem_w_d;
            bubble_q <= bubble_d;
        end
    end

    assign inst_r_o       = inst_r_q;
    assign inst_x_o       = inst_x_q;
    assign inst_m_o       = inst_m_q;
    assign inst_w_o       = inst_w_q;
    assign op_sr_x_o      = op_sr_q;
    assign op_tr_x_o      = op_tr_q;
    assign alu_m_o        = alu_m_q;
    assign alu_w_o        = alu_w_q;
    assign mem_w_o        = mem_w_q;
    assign bubble_count_o = bubble_q;

endmodule

// File: tb/tb_pipeline_stage_regs.sv
// Scoreboard bench for pipeline_stage_regs: stimulus pushes the modelled
// post-edge state, a monitor pops and compares after every rising edge.
module tb_pipeline_stage_regs;

    localparam logic [15:0] NOP = 16'hF000;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] inst_f, rf_sr, rf_tr, alu_x, mem_m;
    logic        en_r, en_x, en_m, en_w;
    logic [4:0]  fwd_sr, fwd_tr;
    logic [15:0] inst_r, inst_x, inst_m, inst_w, op_sr, op_tr;
    logic [15:0] alu_m, alu_w, mem_w, bcount;

    int total = 0;
    int bad   = 0;

    pipeline_stage_regs dut (
        .clk             (clk),
        .rst             (rst),
        .inst_f_i        (inst_f),
        .en_r_i          (en_r),
        .en_x_i          (en_x),
        .en_m_i          (en_m),
        .en_w_i          (en_w),
        .forwarding_sr_i (fwd_sr),
        .forwarding_tr_i (fwd_tr),
        .rf_sr_i         (rf_sr),
        .rf_tr_i         (rf_tr),
        .alu_x_i         (alu_x),
        .mem_m_i         (mem_m),
        .inst_r_o        (inst_r),
        .inst_x_o        (inst_x),
        .inst_m_o        (inst_m),
        .inst_w_o        (inst_w),
        .op_sr_x_o       (op_sr),
        .op_tr_x_o       (op_tr),
        .alu_m_o         (alu_m),
        .alu_w_o         (alu_w),
        .mem_w_o         (mem_w),
        .bubble_count_o  (bcount)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] ir, ix, im, iw, osr, otr, am, aw, mw, bc;
    } exp_t;

    exp_t q[$];

    // Reference model: stage slots 0..3 = R,X,M,W.
    logic [15:0] m_inst[4];
    logic [15:0] m_osr, m_otr, m_am, m_aw, m_mw;
    int          m_bc;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
        end
    endtask

    function automatic logic [15:0] pick(input logic [4:0] v, input logic [15:0] rf,
                                         input logic [15:0] ax, input logic [15:0] mm);
        logic [15:0] src[5];
        src[4] = ax; src[3] = m_am; src[2] = mm; src[1] = m_aw; src[0] = m_mw;
        for (int b = 4; b >= 0; b--)
            if (v[b]) return src[b];
        return rf;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_inst[i] = NOP;
        m_osr = 0; m_otr = 0; m_am = 0; m_aw = 0; m_mw = 0; m_bc = 0;
    endtask

    task automatic step(input logic er, input logic ex, input logic em, input logic ew,
                        input logic [4:0] fs, input logic [4:0] ft, input logic [15:0] f,
                        input logic [15:0] rs, input logic [15:0] rt,
                        input logic [15:0] ax, input logic [15:0] mm);
        logic [15:0] s_sr, s_tr;
        exp_t e;
        @(negedge clk);
        en_r = er; en_x = ex; en_m = em; en_w = ew;
        fwd_sr = fs; fwd_tr = ft; inst_f = f; rf_sr = rs; rf_tr = rt;
        alu_x = ax; mem_m = mm;
        s_sr = pick(fs, rs, ax, mm);
        s_tr = pick(ft, rt, ax, mm);
        // Oldest stage first so each stage reads its predecessor's pre-edge value.
        if (ew) begin m_inst[3] = m_inst[2]; m_aw = m_am; m_mw = mm; end
        if (em) begin m_inst[2] = m_inst[1]; m_am = ax; end
        if (ex) begin
            if (er) begin m_inst[1] = m_inst[0]; m_osr = s_sr; m_otr = s_tr; end
            else begin
                m_inst[1] = NOP; m_osr = 0; m_otr = 0;
                if (m_bc < 65535) m_bc++;
            end
        end
        if (er) m_inst[0] = f;
        e = '{m_inst[0], m_inst[1], m_inst[2], m_inst[3], m_osr, m_otr,
              m_am, m_aw, m_mw, 16'(m_bc)};
        q.push_back(e);
    endtask

    task automatic rstep(input logic er, input logic ex);
        step(er, ex, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
             5'($urandom), 5'($urandom), 16'($urandom), 16'($urandom),
             16'($urandom), 16'($urandom), 16'($urandom));
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_ir"}, inst_r, NOP);
        chk({tag, "_ix"}, inst_x, NOP);
        chk({tag, "_im"}, inst_m, NOP);
        chk({tag, "_iw"}, inst_w, NOP);
        chk({tag, "_osr"}, op_sr, 16'h0);
        chk({tag, "_otr"}, op_tr, 16'h0);
        chk({tag, "_am"}, alu_m, 16'h0);
        chk({tag, "_aw"}, alu_w, 16'h0);
        chk({tag, "_mw"}, mem_w, 16'h0);
        chk({tag, "_bc"}, bcount, 16'h0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            while (q.size() > 0) begin
                e = q.pop_front();
                chk("sb_inst_r", inst_r, e.ir);
                chk("sb_inst_x", inst_x, e.ix);
                chk("sb_inst_m", inst_m, e.im);
                chk("sb_inst_w", inst_w, e.iw);
                chk("sb_op_sr", op_sr, e.osr);
                chk("sb_op_tr", op_tr, e.otr);
                chk("sb_alu_m", alu_m, e.am);
                chk("sb_alu_w", alu_w, e.aw);
                chk("sb_mem_w", mem_w, e.mw);
                chk("sb_bcount", bcount, e.bc);
            end
        end
    end

    initial begin : watchdog
        #5ms;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic [15:0] exp_aw, exp_ir;
        rst = 1'b1;
        en_r = 0; en_x = 0; en_m = 0; en_w = 0;
        fwd_sr = 0; fwd_tr = 0; inst_f = 0; rf_sr = 0; rf_tr = 0; alu_x = 0; mem_m = 0;
        model_reset();
        #12;
        chk_reset_state("por");
        @(negedge clk);
        rst = 1'b0;

        // Straight-line flow
        step(1, 1, 1, 1, 0, 0, 16'h1111, 16'h0101, 16'h0202, 16'h0A01, 16'h0B01);
        step(1, 1, 1, 1, 0, 0, 16'h2222, 16'h0303, 16'h0404, 16'h0A02, 16'h0B02);
        step(1, 1, 1, 1, 0, 0, 16'h3333, 16'h0505, 16'h0606, 16'h0A03, 16'h0B03);
        step(1, 1, 1, 1, 0, 0, 16'h4444, 16'h0707, 16'h0808, 16'h0A04, 16'h0B04);
        settle();
        chk("flow_w_edge4", inst_w, 16'h1111);
        step(1, 1, 1, 1, 0, 0, 16'h5555, 16'h0909, 16'h0A0A, 16'h0A05, 16'h0B05);
        settle();
        chk("flow_w_edge5", inst_w, 16'h2222);

        // Forward priority and fallback
        exp_aw = m_aw;
        step(1, 1, 1, 1, 5'b11111, 5'b00011, 16'h6666, 16'h7777, 16'h8888, 16'hAAAA, 16'hCCCC);
        settle();
        chk("fwd_prio_sr", op_sr, 16'hAAAA);
        chk("fwd_prio_tr", op_tr, exp_aw);
        step(1, 1, 1, 1, 5'b00000, 5'b00000, 16'h7777, 16'h1234, 16'h5678, 16'hAAAB, 16'hCCCD);
        settle();
        chk("nofwd_sr", op_sr, 16'h1234);
        chk("nofwd_tr", op_tr, 16'h5678);

        // Mid-run reset with every stage loaded, observed before any clock edge
        @(negedge clk);
        en_r = 0; en_x = 0; en_m = 0; en_w = 0;
        rst = 1'b1;
        #1;
        chk_reset_state("async");
        model_reset();
        @(negedge clk);
        chk_reset_state("held");
        rst = 1'b0;

        // Load-use stall then forward from M-mem
        step(1, 1, 1, 1, 0, 0, 16'h0123, 16'h1, 16'h2, 16'h3, 16'h4);
        step(1, 1, 1, 1, 0, 0, 16'h0456, 16'h1, 16'h2, 16'h3, 16'h4);
        exp_ir = m_inst[0];
        step(0, 1, 1, 1, 0, 0, 16'h0789, 16'h1, 16'h2, 16'h3, 16'h4);
        settle();
        chk("stall_ix", inst_x, NOP);
        chk("stall_ir_hold", inst_r, exp_ir);
        chk("stall_bc", bcount, 16'd1);
        step(1, 1, 1, 1, 5'b00100, 0, 16'h0789, 16'h1, 16'h2, 16'h3, 16'hBEEF);
        settle();
        chk("lu_fwd_sr", op_sr, 16'hBEEF);

        // Randomized traffic
        for (int i = 0; i < 400; i++)
            rstep($urandom_range(0, 4) != 0, $urandom_range(0, 4) != 0);

        // Saturation: drive bubbles to the ceiling and past it
        while (m_bc < 65534) rstep(0, 1);
        settle();
        chk("sat_pre", bcount, 16'hFFFE);
        for (int i = 0; i < 3; i++) rstep(0, 1);
        settle();
        chk("sat_hold", bcount, 16'hFFFF);
        for (int i = 0; i < 20; i++)
            rstep($urandom_range(0, 1) != 0, $urandom_range(0, 1) != 0);

        @(posedge clk);
        #3;
        if (q.size() != 0) begin
            total++; bad++;
            $display("FAIL sb_drain actual=%0d required=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
